minterm_scanner: RTL and testbench

MINTERM_SCANNER -- requirements
Module: minterm_scanner

---
 rtl/minterm_scanner_pkg.sv | 17 +
 rtl/minterm_scanner.sv | 118 +++++++++++
 tb/tb_minterm_scanner.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/minterm_scanner_pkg.sv
// Shared types and constants for the minterm scanner.
package minterm_scanner_pkg;

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MASK_W = 8;

  localparam logic [MASK_W-1:0] DEFAULT_EXPECTED = 8'h65;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/minterm_scanner.sv
// Steps abc through 0..7, samples f_in after a settle period and compares the mask with EXPECTED.
// Optional sticky error output enabled by defining MINTERM_SCANNER_STICKY_ERR_EN.
module minterm_scanner
  import minterm_scanner_pkg::*;
#(
  parameter int unsigned       SETTLE_CYCLES = 1,
  parameter logic [MASK_W-1:0] EXPECTED      = DEFAULT_EXPECTED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              f_in,
  output logic [IDX_W-1:0]  abc,
  output logic              busy,
  output logic              done,
  output logic [MASK_W-1:0] mask,
  output logic              match
`ifdef MINTERM_SCANNER_STICKY_ERR_EN
  ,
  output logic              err_sticky
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(7);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    abc_d;
  logic                busy_d, done_d, match_d;
  logic [MASK_W-1:0]   mask_d;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abc_d   = abc;
    busy_d  = busy;
    done_d  = 1'b0;
    mask_d  = mask;
    match_d = match;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = '0;
          match_d = 1'b0;
          idx_d   = '0;
          abc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        mask_d[idx_q] = f_in;
        if (idx_q == IDX_LAST) begin
          // match uses the mask including this last sample so it is valid with done
          done_d  = 1'b1;
          match_d = (mask_d == EXPECTED);
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          abc_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      abc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mask    <= '0;
      match   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abc     <= abc_d;
      busy    <= busy_d;
      done    <= done_d;
      mask    <= mask_d;
      match   <= match_d;
    end
  end

`ifdef MINTERM_SCANNER_STICKY_ERR_EN
  // Latches any failing scan until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if ((state_q == FINISH) && (mask != EXPECTED)) begin
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_minterm_scanner.sv
// Self-checking bench for minterm_scanner: vector table, scoreboard and multi-cycle corner cases.
module tb_minterm_scanner;
  import minterm_scanner_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  logic [7:0] func = 8'h65;
  logic       f_in, f_in3;
  logic [2:0] abc, abc3;
  logic       busy, done, match, busy3, done3, match3;
  logic [7:0] mask, mask3;
`ifdef MINTERM_SCANNER_STICKY_ERR_EN
  logic       err_sticky, err_sticky3;
  logic       sticky_exp = 1'b0;
`endif

  // Downstream Boolean function: truth table in func, indexed by abc.
  assign f_in  = func[abc];
  assign f_in3 = func[abc3];

  minterm_scanner u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in),
    .abc(abc), .busy(busy), .done(done), .mask(mask), .match(match)
`ifdef MINTERM_SCANNER_STICKY_ERR_EN
    , .err_sticky(err_sticky)
`endif
  );

  minterm_scanner #(.SETTLE_CYCLES(3), .EXPECTED(8'h65)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .f_in(f_in3),
    .abc(abc3), .busy(busy3), .done(done3), .mask(mask3), .match(match3)
`ifdef MINTERM_SCANNER_STICKY_ERR_EN
    , .err_sticky(err_sticky3)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mask;
    logic       match;
  } exp_t;

  typedef struct {
    logic [7:0] func;
    logic [7:0] exp_mask;
    logic       exp_match;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic       get_done(input int sel);  return (sel != 0) ? done3  : done;  endfunction
  function automatic logic       get_busy(input int sel);  return (sel != 0) ? busy3  : busy;  endfunction
  function automatic logic       get_match(input int sel); return (sel != 0) ? match3 : match; endfunction
  function automatic logic [2:0] get_abc(input int sel);   return (sel != 0) ? abc3   : abc;   endfunction
  function automatic logic [7:0] get_mask(input int sel);  return (sel != 0) ? mask3  : mask;  endfunction

  task automatic on_done(input int sel);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("mask", 32'(get_mask(sel)), 32'(e.mask));
      chk("match", 32'(get_match(sel)), 32'(e.match));
    end
  endtask

  // Drive start for one edge on the selected instance; returns in cycle 1 of the scan.
  task automatic launch(input int sel, input logic [7:0] m, input logic mt);
    sb.push_back('{mask: m, match: mt});
    if (sel != 0) start3 = 1'b1; else start = 1'b1;
    step();
    start  = 1'b0;
    start3 = 1'b0;
  endtask

  // Follows a scan from cycle 1 to done, checking abc pacing; optionally pokes start at poke_cyc.
  task automatic wait_done(input int sel, input int sc, input int poke_cyc, output int cyc);
    cyc = 1;
    while (!get_done(sel) && cyc < 200) begin
      chk("abc_pace", 32'(get_abc(sel)), 32'((cyc - 1) / (sc + 1)));
      chk("busy_in_scan", 32'(get_busy(sel)), 32'd1);
      if (sel == 0) start = (cyc == poke_cyc);
      step();
      cyc++;
    end
    start = 1'b0;
    if (!get_done(sel)) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("abc_at_done", 32'(get_abc(sel)), 32'd7);
      chk("busy_at_done", 32'(get_busy(sel)), 32'd1);
      on_done(sel);
    end
  endtask

  initial begin
    vec_t vecs[9];
    int   cyc;
    int   n_done;
    int   dc[3];

    vecs[0] = '{func: 8'h65, exp_mask: 8'h65, exp_match: 1'b1};
    vecs[1] = '{func: 8'h00, exp_mask: 8'h00, exp_match: 1'b0};
    vecs[2] = '{func: 8'hFF, exp_mask: 8'hFF, exp_match: 1'b0};
    vecs[3] = '{func: 8'h9A, exp_mask: 8'h9A, exp_match: 1'b0};
    vecs[4] = '{func: 8'h64, exp_mask: 8'h64, exp_match: 1'b0};
    vecs[5] = '{func: 8'hE5, exp_mask: 8'hE5, exp_match: 1'b0};
    vecs[6] = '{func: 8'h01, exp_mask: 8'h01, exp_match: 1'b0};
    vecs[7] = '{func: 8'h80, exp_mask: 8'h80, exp_match: 1'b0};
    vecs[8] = '{func: 8'h65, exp_mask: 8'h65, exp_match: 1'b1};

    // Reset state
    #12;
    chk("rst_abc", 32'(abc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mask", 32'(mask), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
`ifdef MINTERM_SCANNER_STICKY_ERR_EN
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    step();

    // Vector table on the default-parameter instance
    foreach (vecs[i]) begin
      func = vecs[i].func;
      launch(0, vecs[i].exp_mask, vecs[i].exp_match);
      wait_done(0, 1, -1, cyc);
      chk("latency_s1", 32'(cyc), 32'd17);
      step();
      chk("done_pulse_low", 32'(done), 32'd0);
      chk("busy_fall", 32'(busy), 32'd0);
      step();
      step();
      chk("mask_hold", 32'(mask), 32'(vecs[i].exp_mask));
      chk("match_hold", 32'(match), 32'(vecs[i].exp_match));
      chk("abc_hold", 32'(abc), 32'd7);
`ifdef MINTERM_SCANNER_STICKY_ERR_EN
      sticky_exp = sticky_exp | (vecs[i].exp_mask != 8'h65);
      chk("err_sticky", 32'(err_sticky), 32'(sticky_exp));
`endif
    end

    // SETTLE_CYCLES=3 instance
    func = 8'h65;
    launch(1, 8'h65, 1'b1);
    wait_done(1, 3, -1, cyc);
    chk("latency_s3", 32'(cyc), 32'd33);
    step();
    chk("busy3_fall", 32'(busy3), 32'd0);

    // start pulsed mid-scan is ignored
    step();
    launch(0, 8'h65, 1'b1);
    wait_done(0, 1, 5, cyc);
    chk("latency_restart_ignored", 32'(cyc), 32'd17);
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (done) n_done++;
    end
    chk("no_extra_done", 32'(n_done), 32'd0);

    // Async reset mid-scan at cycle 9
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_abc", 32'(abc), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_mask", 32'(mask), 32'd0);
    chk("midrst_match", 32'(match), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (done || busy) n_done++;
    end
    chk("no_resume_after_rst", 32'(n_done), 32'd0);
    launch(0, 8'h65, 1'b1);
    wait_done(0, 1, -1, cyc);
    chk("latency_after_rst", 32'(cyc), 32'd17);

    // start held high for 40 cycles: back-to-back scans
    step();
    step();
    sb.push_back('{mask: 8'h65, match: 1'b1});
    sb.push_back('{mask: 8'h65, match: 1'b1});
    sb.push_back('{mask: 8'h65, match: 1'b1});
    start = 1'b1;
    step();
    n_done = 0;
    for (int c = 1; c <= 80 && n_done < 3; c++) begin
      if (done) begin
        dc[n_done] = c;
        n_done++;
        on_done(0);
      end
      if (c == 40) start = 1'b0;
      step();
    end
    start = 1'b0;
    chk("held_done_count", 32'(n_done), 32'd3);
    chk("held_done_1", 32'(dc[0]), 32'd17);
    chk("held_done_2", 32'(dc[1]), 32'd35);
    chk("held_done_3", 32'(dc[2]), 32'd53);
`ifdef MINTERM_SCANNER_STICKY_ERR_EN
    chk("err_sticky_cleared_by_rst", 32'(err_sticky), 32'd0);
    func = 8'h00;
    step();
    step();
    launch(0, 8'h00, 1'b0);
    wait_done(0, 1, -1, cyc);
    step();
    step();
    chk("err_sticky_set", 32'(err_sticky), 32'd1);
    func = 8'h65;
    launch(0, 8'h65, 1'b1);
    wait_done(0, 1, -1, cyc);
    step();
    step();
    chk("err_sticky_stays", 32'(err_sticky), 32'd1);
`endif
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
